// File: rtl/ram_debug_ctrl.sv
// Board-level RAM debug controller.
// Debounces the write/read keys and runs complete RAM transactions against a
// wait-stated port: write followed by a read-back verify, or a plain read.
// Optional address auto-increment, sticky timeout/verify error flags and a
// seven-segment view of the last loaded word.

// Key conditioner: 2-flop synchroniser, stable-level debouncer and a
// one-cycle press pulse on the debounced high-to-low transition.
module ram_debug_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous key into the clock domain (reset to released).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE straight cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= 1'b1;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_W'(DEBOUNCE - 1)) begin
          level_r <= sync2_r;
          cnt_r   <= '0;
          press_r <= ~sync2_r;
        end else begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign press = press_r;

endmodule

module ram_debug_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 8,
  parameter int DEBOUNCE = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                key_wr_n,
  input  logic                key_rd_n,
  input  logic [ADDR_W-1:0]   sw_addr,
  input  logic [DATA_W-1:0]   sw_data,
  input  logic                auto_inc,
  output logic                ram_wen,
  output logic                ram_ren,
  output logic [31:0]         ram_addr,
  output logic [31:0]         ram_store,
  input  logic [31:0]         ram_load,
  input  logic                ram_ready,
  output logic [7*DIGITS-1:0] hex,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_verify
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RB   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  logic [1:0]        state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [ADDR_W-1:0] offset_r;
  logic [31:0]       disp_r;
  logic              err_timeout_r;
  logic              err_verify_r;
  logic              press_wr_s;
  logic              press_rd_s;
  logic              last_wait_s;
  logic              access_done_s;

  // Active-low seven-segment pattern for one hex nibble (bit 6 = segment g).
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  ram_debug_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_wr (
    .clk   (CLK),
    .rst   (RST),
    .key_n (key_wr_n),
    .press (press_wr_s)
  );

  ram_debug_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_rd (
    .clk   (CLK),
    .rst   (RST),
    .key_n (key_rd_n),
    .press (press_rd_s)
  );

  assign last_wait_s   = (wait_cnt_r == WAIT_W'(TIMEOUT - 1));
  // A completed access is the end of a read or of the verify phase of a write.
  assign access_done_s = ram_ready && ((state_r == ST_RB) || (state_r == ST_RD));

  // Transaction sequencer: request latch, wait-state timing, result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= '0;
      addr_r        <= '0;
      data_r        <= '0;
      disp_r        <= 32'd0;
      err_timeout_r <= 1'b0;
      err_verify_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wait_cnt_r <= '0;
          // Write has priority when both presses land in the same cycle.
          if (press_wr_s || press_rd_s) begin
            state_r       <= press_wr_s ? ST_WR : ST_RD;
            addr_r        <= sw_addr + offset_r;
            data_r        <= sw_data;
            err_timeout_r <= 1'b0;
          end
        end
        ST_WR: begin
          if (ram_ready) begin
            state_r    <= ST_RB;
            wait_cnt_r <= '0;
          end else if (last_wait_s) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= '0;
            err_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RB: begin
          if (ram_ready) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= '0;
            err_verify_r <= (ram_load[DATA_W-1:0] != data_r);
            disp_r       <= ram_load;
          end else if (last_wait_s) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= '0;
            err_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RD: begin
          if (ram_ready) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            disp_r     <= ram_load;
          end else if (last_wait_s) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= '0;
            err_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

  // Address offset: held at zero without auto_inc, wraps naturally at 2^ADDR_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      offset_r <= '0;
    end else if (!auto_inc) begin
      offset_r <= '0;
    end else if (access_done_s) begin
      offset_r <= offset_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Enables follow the state register; reset removes them in its own cycle.
  assign ram_wen     = (state_r == ST_WR) && !RST;
  assign ram_ren     = ((state_r == ST_RD) || (state_r == ST_RB)) && !RST;
  assign ram_addr    = 32'(addr_r);
  assign ram_store   = 32'(data_r);
  assign busy        = (state_r != ST_IDLE);
  assign err_timeout = err_timeout_r;
  assign err_verify  = err_verify_r;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign hex[7*gi +: 7] = seg7(disp_r[4*gi +: 4]);
  end

endmodule
